exc_redirect: RTL and testbench

Exception/ERET redirect controller sitting directly downstream of the CP0 block in the dual-issue MIPS pipeline. Captures CP0's flush request and target PC (exception vector 0xbfc00380 or EPC on ERET), holds the redirect until the PC register accepts it, and issues a one-cycle pipeline flush. Tracks in-flight instruction-SRAM requests and marks stale responses for discard, so wrong-path instructions never re-enter the pipeline after a flush.

---
 rtl/exc_redirect.sv | 100 ++++++++++
 tb/tb_exc_redirect.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_redirect.sv
// Exception/ERET redirect controller.
// Holds the CP0 redirect target until the PC register takes it, pulses a
// one-cycle pipeline flush, and tracks in-flight instruction requests so that
// responses to wrong-path requests issued before a flush are marked for discard.
module exc_redirect #(
  parameter int unsigned MAX_OUTSTANDING = 3,
  parameter int unsigned CNT_W           = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  input  logic        pc_ready,
  input  logic        ireq_fire,
  input  logic        iresp_fire,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        pipe_flush,
  output logic        resp_discard,
  output logic        req_allow,
  output logic        busy
);

  localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  typedef enum logic {StIdle, StHold} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               pipe_flush_q;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   disc_q, disc_d;

  // Redirect FSM: a new flush always overrides a pending target.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d = StHold;
          pc_d    = flush_pc;
        end
      end
      StHold: begin
        if (flush_req) begin
          pc_d = flush_pc;
        end else if (pc_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outstanding/discard counters; protocol errors saturate instead of wrapping.
  always_comb begin
    out_d = out_q;
    if (ireq_fire && !iresp_fire) begin
      if (out_q != MaxOut) out_d = out_q + One;
    end else if (iresp_fire && !ireq_fire) begin
      if (out_q != '0) out_d = out_q - One;
    end

    disc_d = disc_q;
    if (flush_req) begin
      // Everything still in flight after this cycle is wrong-path; a response
      // in the flush cycle is already discarded via resp_discard.
      disc_d = out_d;
    end else if (iresp_fire && disc_q != '0) begin
      disc_d = disc_q - One;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_q         <= 32'h0;
      pipe_flush_q <= 1'b0;
      out_q        <= '0;
      disc_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pipe_flush_q <= flush_req;
      out_q        <= out_d;
      disc_q       <= disc_d;
    end
  end

  assign redirect_valid = (state_q == StHold);
  assign redirect_pc    = pc_q;
  assign pipe_flush     = pipe_flush_q;
  assign resp_discard   = iresp_fire & (flush_req | (disc_q != '0));
  assign req_allow      = (state_q == StIdle) & (out_q < MaxOut);
  assign busy           = (state_q == StHold) | (disc_q != '0);

endmodule

// File: tb/tb_exc_redirect.sv
// Self-checking bench for exc_redirect: a cycle model pushes expected outputs
// into a scoreboard as stimulus is driven; they are popped and compared when
// the DUT outputs are sampled, ahead of the next rising edge.
module tb_exc_redirect;

  localparam int unsigned MaxOut = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        pc_ready = 1'b0;
  logic        ireq_fire = 1'b0;
  logic        iresp_fire = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        pipe_flush;
  logic        resp_discard;
  logic        req_allow;
  logic        busy;

  exc_redirect #(
    .MAX_OUTSTANDING(MaxOut),
    .CNT_W          (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_req     (flush_req),
    .flush_pc      (flush_pc),
    .pc_ready      (pc_ready),
    .ireq_fire     (ireq_fire),
    .iresp_fire    (iresp_fire),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pipe_flush    (pipe_flush),
    .resp_discard  (resp_discard),
    .req_allow     (req_allow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        pf;
    logic        disc;
    logic        allow;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int pf_cnt   = 0;
  int disc_cnt = 0;

  // Reference model state.
  bit          m_hold = 0;
  logic [31:0] m_pc   = 32'h0;
  bit          m_pf   = 0;
  int          m_out  = 0;
  int          m_disc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_pc = 32'h0; m_pf = 0; m_out = 0; m_disc = 0;
  endtask

  task automatic model_clock(input bit fr, input logic [31:0] fpc, input bit pr, rq, rs);
    int n;
    if (fr) begin
      m_hold = 1;
      m_pc   = fpc;
    end else if (m_hold && pr) begin
      m_hold = 0;
    end
    m_pf = fr;
    n = m_out + int'(rq) - int'(rs);
    if (n < 0) n = 0;
    if (n > int'(MaxOut)) n = MaxOut;
    m_out = n;
    if (fr) m_disc = n;
    else if (rs && m_disc > 0) m_disc = m_disc - 1;
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic step(input bit fr, input logic [31:0] fpc, input bit pr, rq, rs);
    exp_t e;
    exp_t g;
    flush_req  = fr;
    flush_pc   = fpc;
    pc_ready   = pr;
    ireq_fire  = rq;
    iresp_fire = rs;
    e.rv    = m_hold;
    e.pc    = m_pc;
    e.pf    = m_pf;
    e.disc  = rs && (fr || m_disc != 0);
    e.allow = !m_hold && (m_out < int'(MaxOut));
    e.busy  = m_hold || (m_disc != 0);
    sb.push_back(e);
    #3;
    g = sb.pop_front();
    check("redirect_valid", 32'(redirect_valid), 32'(g.rv));
    check("redirect_pc", redirect_pc, g.pc);
    check("pipe_flush", 32'(pipe_flush), 32'(g.pf));
    check("resp_discard", 32'(resp_discard), 32'(g.disc));
    check("req_allow", 32'(req_allow), 32'(g.allow));
    check("busy", 32'(busy), 32'(g.busy));
    pf_cnt   += int'(pipe_flush);
    disc_cnt += int'(resp_discard);
    if (rst) model_clock(fr, fpc, pr, rq, rs);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit pr);
    for (int i = 0; i < n; i++) step(0, 32'h0, pr, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    // Reset held with random inputs: model stays at reset values.
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++)
      step(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    rst = 1'b1;
    idle(2, 0);
    check("rst_allow", 32'(req_allow), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);

    // Simple exception, pc_ready from T+1.
    pf_cnt = 0;
    step(1, 32'hbfc00380, 0, 0, 0);
    check("exc_valid_t1", 32'(redirect_valid), 32'h1);
    check("exc_pc_t1", redirect_pc, 32'hbfc00380);
    step(0, 32'h0, 1, 0, 0);
    check("exc_valid_t2", 32'(redirect_valid), 32'h0);
    idle(1, 1);
    check("exc_pf_pulses", 32'(pf_cnt), 32'd1);

    // Held redirect, then an override arriving together with pc_ready.
    pf_cnt = 0;
    step(1, 32'hbfc00380, 0, 0, 0);
    idle(4, 0);
    check("hold_still_valid", 32'(redirect_valid), 32'h1);
    step(1, 32'h80001234, 1, 0, 0);
    check("ovr_valid", 32'(redirect_valid), 32'h1);
    check("ovr_pc", redirect_pc, 32'h80001234);
    step(0, 32'h0, 1, 0, 0);
    check("ovr_released", 32'(redirect_valid), 32'h0);
    idle(1, 0);
    check("ovr_pf_pulses", 32'(pf_cnt), 32'd2);

    // Stale discard: two outstanding, third request in the flush cycle.
    step(0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 0, 1, 0);
    disc_cnt = 0;
    step(1, 32'hbfc00380, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0, 1);
    check("stale_discards", 32'(disc_cnt), 32'd3);
    step(0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 0, 0, 1);
    check("stale_post_flush_kept", 32'(disc_cnt), 32'd3);
    check("stale_busy", 32'(busy), 32'h0);

    // Flush and response in the same cycle.
    step(0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 0, 1, 0);
    disc_cnt = 0;
    step(1, 32'hbfc00380, 0, 0, 1);
    check("sim_busy", 32'(busy), 32'h1);
    step(0, 32'h0, 1, 0, 1);
    check("sim_discards", 32'(disc_cnt), 32'd2);
    check("sim_busy_after", 32'(busy), 32'h0);

    // Saturation and request gating during HOLD.
    for (int i = 0; i < int'(MaxOut); i++) step(0, 32'h0, 0, 1, 0);
    check("sat_allow", 32'(req_allow), 32'h0);
    step(0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 0, 0, 1);
    check("sat_allow_after_resp", 32'(req_allow), 32'h1);
    step(1, 32'hbfc00380, 0, 0, 0);
    check("hold_gates_allow", 32'(req_allow), 32'h0);

    // Asynchronous reset mid-HOLD with pending discards.
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(redirect_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_allow", 32'(req_allow), 32'h1);
    check("arst_pc", redirect_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 7) == 0), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
